spi_recv_sipo: RTL and testbench

SPI receive-side block: a serial-in/parallel-out slave that accepts frames from the team's SPI transmitter over cs/sclk/si and presents each completed word on a parallel bus. Frames are MSB-first and cs is active-low. Data is launched on the falling sclk edge and sampled here on the rising edge. All external SPI inputs are synchronized into the local clk_in domain. Completed words are handed downstream with a valid/ack handshake, and protocol violations and overruns are flagged.

---
 rtl/spi_recv_sipo_pkg.sv | 10 +
 rtl/spi_recv_sipo_sync.sv | 18 +
 rtl/spi_recv_sipo.sv | 87 ++++++++
 tb/tb_spi_recv_sipo.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/spi_recv_sipo_pkg.sv
// spi_recv_sipo_pkg: shared FSM state encoding and default frame length
package spi_recv_sipo_pkg;
  localparam int SPI_COUNT = 5;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10,
    ERROR = 2'b11
  } state_t;
endpackage

// File: rtl/spi_recv_sipo_sync.sv
// spi_recv_sipo_sync: 2-flop synchronizer plus previous-value flop for edge detection
module spi_recv_sipo_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic synced,
  output logic rise,
  output logic fall
);
  logic [2:0] q;
  always_ff @(posedge clk_in) begin
    if (reset) q <= '0;
    else q <= {q[1:0], d};
  end
  assign synced = q[1];
  assign rise = ~q[2] & q[1];
  assign fall = q[2] & ~q[1];
endmodule

// File: rtl/spi_recv_sipo.sv
// spi_recv_sipo: SPI slave receiver, MSB-first frames delivered on a valid/ack parallel port
module spi_recv_sipo
  import spi_recv_sipo_pkg::*;
#(
  parameter int spi_count = SPI_COUNT
) (
  input  logic                             clk_in,
  input  logic                             reset,
  input  logic                             cs,
  input  logic                             sclk,
  input  logic                             si,
  output logic [spi_count-1:0]             po,
  output logic                             po_valid,
  input  logic                             po_ack,
  output logic                             busy,
  output logic [$clog2(spi_count+1)-1:0]   bit_cnt,
  output logic                             error,
  output logic                             overrun,
  output logic [1:0]                       state
);
  localparam int CW = $clog2(spi_count+1);
  localparam logic [CW-1:0] LAST = CW'(spi_count-1);
  state_t st;
  logic [spi_count-2:0] shift_reg;
  logic [spi_count-1:0] word;
  logic [1:0] si_sync;
  logic cs_synced, cs_rise, cs_fall, sclk_rise, sclk_synced_unused, sclk_fall_unused;
  spi_recv_sipo_sync u_cs (
    .clk_in(clk_in), .reset(reset), .d(cs),
    .synced(cs_synced), .rise(cs_rise), .fall(cs_fall)
  );
  spi_recv_sipo_sync u_sclk (
    .clk_in(clk_in), .reset(reset), .d(sclk),
    .synced(sclk_synced_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );
  always_ff @(posedge clk_in) begin
    if (reset) si_sync <= '0;
    else si_sync <= {si_sync[0], si};
  end
  assign word = {shift_reg, si_sync[1]};
  assign busy = st == SHIFT || st == DONE;
  assign state = st;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      st <= IDLE;
      shift_reg <= '0;
      bit_cnt <= '0;
      po <= '0;
      po_valid <= 1'b0;
      error <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (po_valid && po_ack) po_valid <= 1'b0;
      case (st)
        IDLE: if (cs_fall) begin
          st <= SHIFT;
          shift_reg <= '0;
          bit_cnt <= '0;
          error <= 1'b0;
        end
        SHIFT: if (cs_rise) begin
          // a rise coinciding with the last sclk edge still aborts the frame
          st <= bit_cnt == '0 ? IDLE : ERROR;
          error <= bit_cnt != '0;
        end else if (sclk_rise) begin
          shift_reg <= word[spi_count-2:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            st <= DONE;
            if (!po_valid || po_ack) begin
              po <= word;
              po_valid <= 1'b1;
            end else overrun <= 1'b1;
          end
        end
        DONE: if (cs_rise) st <= IDLE;
        else if (sclk_rise && !cs_synced) begin
          st <= ERROR;
          error <= 1'b1;
        end
        // leave once cs is released, so a rise consumed on entry still exits
        ERROR: if (cs_synced) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_recv_sipo.sv
// tb_spi_recv_sipo: directed scenario tests for the SPI receiver
module tb_spi_recv_sipo;
  logic clk_in = 1'b0, reset = 1'b0, cs = 1'b1, sclk = 1'b0, si = 1'b0, po_ack = 1'b0;
  logic [4:0] po;
  logic po_valid, busy, error, overrun;
  logic [2:0] bit_cnt;
  logic [1:0] state;
  int passed = 0, total = 0;

  spi_recv_sipo #(.spi_count(5)) dut (
    .clk_in(clk_in), .reset(reset), .cs(cs), .sclk(sclk), .si(si),
    .po(po), .po_valid(po_valid), .po_ack(po_ack), .busy(busy),
    .bit_cnt(bit_cnt), .error(error), .overrun(overrun), .state(state)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int k);
    repeat (k) @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);
  endtask

  // sclk = clk_in/10; optional po_ack pulse lands in the cycle the last bit is detected
  task automatic frame(input logic [15:0] bits, input int n, input bit ack_last, input bit release_cs);
    cs = 1'b0;
    tick(6);
    for (int i = n - 1; i >= 0; i--) begin
      si = bits[i];
      tick(5);
      sclk = 1'b1;
      if (ack_last && i == 0) begin
        tick(2);
        po_ack = 1'b1;
        tick(1);
        po_ack = 1'b0;
        tick(2);
      end else tick(5);
      sclk = 1'b0;
    end
    if (release_cs) begin
      tick(6);
      cs = 1'b1;
      tick(8);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (po !== 5'b0) $display("FAIL reset_po got %b want %b", po, 5'b0); else passed++;
    total++; if (po_valid !== 1'b0) $display("FAIL reset_po_valid got %b want 0", po_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (bit_cnt !== 3'd0) $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); else passed++;
    total++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
    total++; if (state !== 2'b00) $display("FAIL reset_state got %b want 00", state); else passed++;
  endtask

  task automatic test_nominal();
    do_reset();
    frame(16'b10011, 5, 1'b0, 1'b0);
    total++; if (state !== 2'b10) $display("FAIL nominal_state_done got %b want 10", state); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL nominal_busy got %b want 1", busy); else passed++;
    total++; if (po !== 5'b10011) $display("FAIL nominal_po got %b want %b", po, 5'b10011); else passed++;
    total++; if (po_valid !== 1'b1) $display("FAIL nominal_po_valid got %b want 1", po_valid); else passed++;
    total++; if (bit_cnt !== 3'd5) $display("FAIL nominal_bit_cnt got %0d want 5", bit_cnt); else passed++;
    tick(6);
    cs = 1'b1;
    tick(8);
    total++; if (state !== 2'b00) $display("FAIL nominal_state_idle got %b want 00", state); else passed++;
    total++; if (error !== 1'b0) $display("FAIL nominal_error got %b want 0", error); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL nominal_overrun got %b want 0", overrun); else passed++;
    po_ack = 1'b1;
    tick(1);
    po_ack = 1'b0;
    total++; if (po_valid !== 1'b0) $display("FAIL nominal_ack_clear got %b want 0", po_valid); else passed++;
  endtask

  task automatic test_short();
    bit seen_err = 1'b0;
    do_reset();
    frame(16'b101, 3, 1'b0, 1'b0);
    total++; if (bit_cnt !== 3'd3) $display("FAIL short_bit_cnt got %0d want 3", bit_cnt); else passed++;
    tick(6);
    cs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (state == 2'b11) seen_err = 1'b1;
    end
    total++; if (seen_err !== 1'b1) $display("FAIL short_saw_error_state got %b want 1", seen_err); else passed++;
    total++; if (state !== 2'b00) $display("FAIL short_state_idle got %b want 00", state); else passed++;
    total++; if (error !== 1'b1) $display("FAIL short_error got %b want 1", error); else passed++;
    total++; if (po_valid !== 1'b0) $display("FAIL short_po_valid got %b want 0", po_valid); else passed++;
    cs = 1'b0;
    tick(6);
    total++; if (error !== 1'b0) $display("FAIL short_error_clear got %b want 0", error); else passed++;
    cs = 1'b1;
    tick(8);
    total++; if (state !== 2'b00) $display("FAIL short_empty_frame_state got %b want 00", state); else passed++;
  endtask

  task automatic test_overrun();
    do_reset();
    frame(16'b11000, 5, 1'b0, 1'b1);
    frame(16'b00111, 5, 1'b0, 1'b1);
    total++; if (po !== 5'b11000) $display("FAIL overrun_po got %b want %b", po, 5'b11000); else passed++;
    total++; if (po_valid !== 1'b1) $display("FAIL overrun_po_valid got %b want 1", po_valid); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL overrun_flag got %b want 1", overrun); else passed++;
    total++; if (error !== 1'b0) $display("FAIL overrun_error got %b want 0", error); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame(16'b11000, 5, 1'b0, 1'b1);
    frame(16'b00111, 5, 1'b1, 1'b1);
    total++; if (po !== 5'b00111) $display("FAIL b2b_po got %b want %b", po, 5'b00111); else passed++;
    total++; if (po_valid !== 1'b1) $display("FAIL b2b_po_valid got %b want 1", po_valid); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun); else passed++;
  endtask

  task automatic test_extra_bit();
    do_reset();
    frame(16'b101101, 6, 1'b0, 1'b0);
    total++; if (po !== 5'b10110) $display("FAIL extra_po got %b want %b", po, 5'b10110); else passed++;
    total++; if (po_valid !== 1'b1) $display("FAIL extra_po_valid got %b want 1", po_valid); else passed++;
    total++; if (error !== 1'b1) $display("FAIL extra_error got %b want 1", error); else passed++;
    total++; if (state !== 2'b11) $display("FAIL extra_state got %b want 11", state); else passed++;
    tick(6);
    cs = 1'b1;
    tick(8);
    total++; if (state !== 2'b00) $display("FAIL extra_state_idle got %b want 00", state); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame(16'b01, 2, 1'b0, 1'b0);
    total++; if (bit_cnt !== 3'd2) $display("FAIL midrst_pre_bit_cnt got %0d want 2", bit_cnt); else passed++;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    total++; if (state !== 2'b00) $display("FAIL midrst_state got %b want 00", state); else passed++;
    total++; if (bit_cnt !== 3'd0) $display("FAIL midrst_bit_cnt got %0d want 0", bit_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    frame(16'b110, 3, 1'b0, 1'b1);
    total++; if (bit_cnt !== 3'd0) $display("FAIL midrst_ignored_bit_cnt got %0d want 0", bit_cnt); else passed++;
    total++; if (po_valid !== 1'b0) $display("FAIL midrst_ignored_po_valid got %b want 0", po_valid); else passed++;
    total++; if (error !== 1'b0) $display("FAIL midrst_ignored_error got %b want 0", error); else passed++;
    frame(16'b01010, 5, 1'b0, 1'b1);
    total++; if (po !== 5'b01010) $display("FAIL midrst_next_po got %b want %b", po, 5'b01010); else passed++;
    total++; if (po_valid !== 1'b1) $display("FAIL midrst_next_po_valid got %b want 1", po_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_overrun();
    test_back_to_back();
    test_extra_bit();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
